// File: rtl/control_sequencer_if.sv
// Bundle between the hardwired control unit and the 32-bit datapath:
// instruction/memory status in, per-step control strobes out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ready;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin;
  logic Yin, Zin, Cout, ZLOout, ZHIout, HIout, LOout, InPortout, OPin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;

  logic [4:0] ALUSelection;
  logic       run;
  logic [3:0] present_state;

  // Control unit side: consumes IR/mem_ready, drives every strobe.
  modport master (
    input  IR, mem_ready,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin,
    output Yin, Zin, Cout, ZLOout, ZHIout, HIout, LOout, InPortout, OPin,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output ALUSelection, run, present_state
  );

  // Datapath side: supplies IR/mem_ready, obeys the strobes.
  modport slave (
    output IR, mem_ready,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin,
    input  Yin, Zin, Cout, ZLOout, ZHIout, HIout, LOout, InPortout, OPin,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  ALUSelection, run, present_state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch in T0..T2, opcode-specific execute in
// T3..T7, back to T0. Outputs decode only the registered step and IR.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00001,
  parameter logic [4:0] ALU_SUB = 5'b00010,
  parameter logic [4:0] ALU_AND = 5'b00011,
  parameter logic [4:0] ALU_OR  = 5'b00100
) (
  input logic                  clk,
  input logic                  clr,
  control_sequencer_if.master  bus
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [4:0] w_opcode;
  logic       w_is_ld, w_is_st, w_is_mem, w_is_alu3, w_is_addi;
  logic [4:0] w_alu3_sel;

  assign w_opcode  = bus.IR[31:27];
  assign w_is_ld   = (w_opcode == OP_LD);
  assign w_is_st   = (w_opcode == OP_ST);
  assign w_is_mem  = w_is_ld | w_is_st;
  assign w_is_alu3 = (w_opcode == OP_ADD) | (w_opcode == OP_SUB) |
                     (w_opcode == OP_AND) | (w_opcode == OP_OR);
  assign w_is_addi = (w_opcode == OP_ADDI);

  // Map the three-register ALU opcodes onto ALU selection codes.
  always_comb begin
    w_alu3_sel = ALU_ADD;
    case (w_opcode)
      OP_SUB:  w_alu3_sel = ALU_SUB;
      OP_AND:  w_alu3_sel = ALU_AND;
      OP_OR:   w_alu3_sel = ALU_OR;
      default: w_alu3_sel = ALU_ADD;
    endcase
  end

  // Step sequencing: fetch, opcode-dependent execute length, memory waits.
  always_comb begin
    w_next_state = S_RESET;
    case (r_state)
      S_RESET: w_next_state = S_T0;
      S_T0:    w_next_state = S_T1;
      S_T1:    w_next_state = bus.mem_ready ? S_T2 : S_T1;
      S_T2:    w_next_state = S_T3;
      S_T3: begin
        if (w_opcode == OP_HALT)                    w_next_state = S_HALT;
        else if (w_is_alu3 | w_is_addi | w_is_mem) w_next_state = S_T4;
        else                                        w_next_state = S_T0;
      end
      S_T4:    w_next_state = S_T5;
      S_T5:    w_next_state = w_is_mem ? S_T6 : S_T0;
      S_T6: begin
        if (w_is_ld)      w_next_state = bus.mem_ready ? S_T7 : S_T6;
        else if (w_is_st) w_next_state = S_T7;
        else              w_next_state = S_T0;
      end
      S_T7:    w_next_state = (w_is_st && !bus.mem_ready) ? S_T7 : S_T0;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RESET;
    endcase
  end

  // State register; clr overrides every transition, including memory waits.
  // NOTE: registered state is updated with <= so all flops sample together.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_RESET;
    else     r_state <= w_next_state;
  end

  assign bus.present_state = r_state;
  assign bus.run           = (r_state >= S_T0) && (r_state <= S_T7);

  // Moore strobe decode from the current step and the latched opcode.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
    bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.MDRread = 1'b0; bus.wren = 1'b0;
    bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Cout = 1'b0;
    bus.ZLOout = 1'b0; bus.ZHIout = 1'b0; bus.HIout = 1'b0; bus.LOout = 1'b0;
    bus.InPortout = 1'b0; bus.OPin = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0;
    bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.ALUSelection = 5'b00000;
    case (r_state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        bus.ALUSelection = ALU_ADD;
      end
      S_T1: begin
        bus.ZLOout = 1'b1; bus.PCin = 1'b1; bus.MDRread = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (w_is_alu3 | w_is_addi) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (w_is_mem) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else begin
          case (w_opcode)
            OP_MFHI: begin bus.HIout = 1'b1;     bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFLO: begin bus.LOout = 1'b1;     bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OPin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (w_is_alu3) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
          bus.ALUSelection = w_alu3_sel;
        end else if (w_is_addi | w_is_mem) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUSelection = ALU_ADD;
        end
      end
      S_T5: begin
        if (w_is_alu3 | w_is_addi) begin
          bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (w_is_mem) begin
          bus.ZLOout = 1'b1; bus.MARin = 1'b1;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          bus.MDRread = 1'b1; bus.MDRin = 1'b1;
        end else if (w_is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (w_is_st) begin
          bus.wren = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
